// File: rtl/csum_stream_engine.sv
// csum_stream_engine
//   Streaming RFC 1071 ones'-complement checksum engine. It taps an AXI-Stream
//   frame path passively and never applies backpressure. For every frame it
//   sums 16-bit network-order words from byte START_OFFSET to the end of the
//   frame. It produces the checksum with the 16-bit field at SKIP_OFFSET
//   zeroed (generate), and a verify flag computed with that field included.
//
//   Optional build macro: CSUM_STREAM_SEED_EN adds the csum_seed input. The
//   seed is sampled on the first beat of each frame and is used as the
//   starting value of the accumulator.
//
//   Ports:
//     clk, reset           clock, synchronous active-high reset
//     s_t*                 snooped stream beat (transfer when s_tvalid & s_tready)
//     csum_seed            (CSUM_STREAM_SEED_EN only) pseudo-header seed
//     csum_valid/ready     1-deep result buffer handshake
//     csum                 ~fold(sum), checksum field treated as zero
//     csum_ok              field present and full sum folds to 0xFFFF
//     csum_err             OR of s_tuser over the frame
//     csum_bytes           bytes summed, saturating at 0xFFFF
//     csum_overflow        sticky: an unconsumed result was overwritten
module csum_stream_engine #(
    parameter int DATA_WIDTH   = 64,
    parameter int START_OFFSET = 14,
    parameter int SKIP_OFFSET  = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_tkeep,
    input  logic                    s_tlast,
    input  logic                    s_tuser,
    input  logic                    s_tvalid,
    input  logic                    s_tready,
`ifdef CSUM_STREAM_SEED_EN
    input  logic [15:0]             csum_seed,
`endif
    output logic                    csum_valid,
    input  logic                    csum_ready,
    output logic [15:0]             csum,
    output logic                    csum_ok,
    output logic                    csum_err,
    output logic [15:0]             csum_bytes,
    output logic                    csum_overflow
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int WORDS = DATA_WIDTH / 16;
    // One extra bit beyond 16+clog2(WORDS) leaves room for the seed.
    localparam int SUMW  = 17 + $clog2(WORDS);
    localparam int CNTW  = $clog2(BYTES + 1);

    // Beat-level combinational signals
    logic            xfer, first;
    logic [31:0]     base, p;
    logic [7:0]      hi_b, lo_b;
    logic            in_range, hi_inc, lo_inc;
    logic [15:0]     seed_c;

    // Frame position
    logic [15:0]     beat_idx_q, beat_idx_d;

    // S1: per-beat registers
    logic            s1_valid_q, s1_valid_d;
    logic            s1_first_q, s1_first_d;
    logic            s1_last_q, s1_last_d;
    logic            s1_user_q, s1_user_d;
    logic [SUMW-1:0] s1_sum_q, s1_sum_d;
    logic [CNTW-1:0] s1_cnt_q, s1_cnt_d;
    logic            s1_fhi_v_q, s1_fhi_v_d;
    logic            s1_flo_v_q, s1_flo_v_d;
    logic [15:0]     s1_field_q, s1_field_d;

    // S2: per-frame accumulation
    logic [31:0]     acc_q, acc_d;
    logic            err_q, err_d;
    logic [15:0]     bytes_q, bytes_d;
    logic [16:0]     bytes_sum;
    logic [15:0]     field_q, field_d;
    logic            fhi_seen_q, fhi_seen_d;
    logic            flo_seen_q, flo_seen_d;
    logic            done_q, done_d;

    // S3: output buffer
    logic [16:0]     f1, t;
    logic [15:0]     fs, full;
    logic            csum_valid_q, csum_valid_d;
    logic [15:0]     csum_q, csum_d;
    logic            csum_ok_q, csum_ok_d;
    logic            csum_err_q, csum_err_d;
    logic [15:0]     csum_bytes_q, csum_bytes_d;
    logic            csum_overflow_q, csum_overflow_d;

    always_comb begin : beat_comb
`ifdef CSUM_STREAM_SEED_EN
        seed_c = csum_seed;
`else
        seed_c = '0;
`endif
        xfer       = s_tvalid & s_tready;
        first      = (beat_idx_q == '0);
        base       = 32'(beat_idx_q) * 32'(BYTES);
        p          = '0;
        hi_b       = '0;
        lo_b       = '0;
        in_range   = 1'b0;
        hi_inc     = 1'b0;
        lo_inc     = 1'b0;
        s1_sum_d   = '0;
        s1_cnt_d   = '0;
        s1_fhi_v_d = 1'b0;
        s1_flo_v_d = 1'b0;
        s1_field_d = '0;
        for (int unsigned w = 0; w < WORDS; w++) begin
            p        = base + 32'(2 * w);
            hi_b     = s_tdata[16*w +: 8];
            lo_b     = s_tdata[16*w+8 +: 8];
            // START_OFFSET is even, so both bytes of a word share the range test.
            in_range = (p >= 32'(START_OFFSET));
            hi_inc   = s_tkeep[2*w] & in_range;
            lo_inc   = s_tkeep[2*w+1] & in_range;
            s1_cnt_d = s1_cnt_d + CNTW'(hi_inc) + CNTW'(lo_inc);
            // The field is even-aligned, so it always occupies one whole word.
            if (p == 32'(SKIP_OFFSET)) begin
                s1_fhi_v_d = hi_inc;
                s1_flo_v_d = lo_inc;
                s1_field_d = {hi_b, lo_b};
                hi_inc     = 1'b0;
                lo_inc     = 1'b0;
            end
            s1_sum_d = s1_sum_d + SUMW'({hi_inc ? hi_b : 8'h00, lo_inc ? lo_b : 8'h00});
        end
        if (first) begin
            s1_sum_d = s1_sum_d + SUMW'(seed_c);
        end
        s1_valid_d = xfer;
        s1_first_d = first;
        s1_last_d  = s_tlast;
        s1_user_d  = s_tuser;

        beat_idx_d = beat_idx_q;
        if (xfer) begin
            if (s_tlast) begin
                beat_idx_d = '0;
            end else if (beat_idx_q != 16'hFFFF) begin
                beat_idx_d = beat_idx_q + 16'd1;
            end
        end
    end

    always_comb begin : frame_comb
        acc_d      = acc_q;
        err_d      = err_q;
        bytes_d    = bytes_q;
        field_d    = field_q;
        fhi_seen_d = fhi_seen_q;
        flo_seen_d = flo_seen_q;
        bytes_sum  = {1'b0, bytes_q} + 17'(s1_cnt_q);
        done_d     = s1_valid_q & s1_last_q;
        if (s1_valid_q) begin
            if (s1_first_q) begin
                // First beat loads, so back-to-back frames need no idle cycle.
                acc_d      = 32'(s1_sum_q);
                err_d      = s1_user_q;
                bytes_d    = 16'(s1_cnt_q);
                field_d    = s1_field_q;
                fhi_seen_d = s1_fhi_v_q;
                flo_seen_d = s1_flo_v_q;
            end else begin
                acc_d      = acc_q + 32'(s1_sum_q);
                err_d      = err_q | s1_user_q;
                bytes_d    = bytes_sum[16] ? 16'hFFFF : bytes_sum[15:0];
                fhi_seen_d = fhi_seen_q | s1_fhi_v_q;
                flo_seen_d = flo_seen_q | s1_flo_v_q;
                if (s1_fhi_v_q) field_d[15:8] = s1_field_q[15:8];
                if (s1_flo_v_q) field_d[7:0]  = s1_field_q[7:0];
            end
        end
    end

    always_comb begin : out_comb
        f1   = {1'b0, acc_q[15:0]} + {1'b0, acc_q[31:16]};
        fs   = f1[15:0] + 16'(f1[16]);
        t    = {1'b0, fs} + {1'b0, field_q};
        full = t[15:0] + 16'(t[16]);

        csum_valid_d    = csum_valid_q;
        csum_d          = csum_q;
        csum_ok_d       = csum_ok_q;
        csum_err_d      = csum_err_q;
        csum_bytes_d    = csum_bytes_q;
        csum_overflow_d = csum_overflow_q;
        if (done_q) begin
            csum_valid_d = 1'b1;
            csum_d       = ~fs;
            csum_ok_d    = fhi_seen_q & flo_seen_q & (full == 16'hFFFF);
            csum_err_d   = err_q;
            csum_bytes_d = bytes_q;
            if (csum_valid_q && !csum_ready) begin
                csum_overflow_d = 1'b1;
            end
        end else if (csum_valid_q && csum_ready) begin
            csum_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_idx_q      <= '0;
            s1_valid_q      <= 1'b0;
            s1_first_q      <= 1'b0;
            s1_last_q       <= 1'b0;
            s1_user_q       <= 1'b0;
            s1_sum_q        <= '0;
            s1_cnt_q        <= '0;
            s1_fhi_v_q      <= 1'b0;
            s1_flo_v_q      <= 1'b0;
            s1_field_q      <= '0;
            acc_q           <= '0;
            err_q           <= 1'b0;
            bytes_q         <= '0;
            field_q         <= '0;
            fhi_seen_q      <= 1'b0;
            flo_seen_q      <= 1'b0;
            done_q          <= 1'b0;
            csum_valid_q    <= 1'b0;
            csum_q          <= '0;
            csum_ok_q       <= 1'b0;
            csum_err_q      <= 1'b0;
            csum_bytes_q    <= '0;
            csum_overflow_q <= 1'b0;
        end else begin
            beat_idx_q      <= beat_idx_d;
            s1_valid_q      <= s1_valid_d;
            s1_first_q      <= s1_first_d;
            s1_last_q       <= s1_last_d;
            s1_user_q       <= s1_user_d;
            s1_sum_q        <= s1_sum_d;
            s1_cnt_q        <= s1_cnt_d;
            s1_fhi_v_q      <= s1_fhi_v_d;
            s1_flo_v_q      <= s1_flo_v_d;
            s1_field_q      <= s1_field_d;
            acc_q           <= acc_d;
            err_q           <= err_d;
            bytes_q         <= bytes_d;
            field_q         <= field_d;
            fhi_seen_q      <= fhi_seen_d;
            flo_seen_q      <= flo_seen_d;
            done_q          <= done_d;
            csum_valid_q    <= csum_valid_d;
            csum_q          <= csum_d;
            csum_ok_q       <= csum_ok_d;
            csum_err_q      <= csum_err_d;
            csum_bytes_q    <= csum_bytes_d;
            csum_overflow_q <= csum_overflow_d;
        end
    end

    assign csum_valid    = csum_valid_q;
    assign csum          = csum_q;
    assign csum_ok       = csum_ok_q;
    assign csum_err      = csum_err_q;
    assign csum_bytes    = csum_bytes_q;
    assign csum_overflow = csum_overflow_q;

endmodule

// File: tb/tb_csum_stream_engine.sv
module tb_csum_stream_engine;

    localparam int DW    = 64;
    localparam int BY    = DW / 8;
    localparam int START = 14;
    localparam int SKIP  = 24;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic [BY-1:0] s_tkeep = '0;
    logic          s_tlast = 1'b0, s_tuser = 1'b0, s_tvalid = 1'b0, s_tready = 1'b0;
    logic [15:0]   seed = '0;
    logic          csum_valid, csum_ready = 1'b1;
    logic [15:0]   csum, csum_bytes;
    logic          csum_ok, csum_err, csum_overflow;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] frm[$];
    logic [7:0] ip_hdr[20] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                               8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};

    always #5 clk = ~clk;

    csum_stream_engine #(.DATA_WIDTH(DW), .START_OFFSET(START), .SKIP_OFFSET(SKIP)) dut (
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
`ifdef CSUM_STREAM_SEED_EN
        .csum_seed(seed),
`endif
        .csum_valid(csum_valid), .csum_ready(csum_ready), .csum(csum), .csum_ok(csum_ok),
        .csum_err(csum_err), .csum_bytes(csum_bytes), .csum_overflow(csum_overflow)
    );

    // Reference: RFC 1071 sum over the frame as a byte array.
    function automatic void model(input logic [7:0] f[$], input logic [15:0] sd,
                                  output logic [15:0] c, output logic ok, output logic [15:0] nb);
        int unsigned sum, fsum;
        int len;
        logic [7:0] hi, lo;
        len = f.size();
        sum = 0;
`ifdef CSUM_STREAM_SEED_EN
        sum = 32'(sd);
`else
        if (sd != 16'h0) sum = 0;
`endif
        for (int q = START; q < len; q += 2) begin
            hi = (q == SKIP) ? 8'h00 : f[q];
            lo = (q + 1 < len && q + 1 != SKIP + 1) ? f[q+1] : 8'h00;
            sum += 32'({hi, lo});
        end
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
        c = ~sum[15:0];
        ok = 1'b0;
        if (len >= SKIP + 2) begin
            fsum = sum + 32'({f[SKIP], f[SKIP+1]});
            while (fsum > 32'hFFFF) fsum = (fsum & 32'hFFFF) + (fsum >> 16);
            ok = (fsum == 32'hFFFF);
        end
        nb = (len > START) ? 16'(len - START) : 16'h0;
    endfunction

    task automatic build_ipv4();
        frm.delete();
        for (int i = 0; i < 14; i++) frm.push_back(8'(8'h10 + i));
        for (int i = 0; i < 20; i++) frm.push_back(ip_hdr[i]);
    endtask

    // mode 0: ready always; 1: ready toggles each cycle; 2: random ready.
    task automatic send_frame(input int mode, input int user_beat, input bit no_last);
        int len, nb, q;
        bit ph, done;
        len = frm.size();
        nb = (len + BY - 1) / BY;
        ph = 1'b0;
        for (int b = 0; b < nb; b++) begin
            done = 1'b0;
            while (!done) begin
                @(negedge clk);
                s_tvalid = 1'b1;
                s_tlast = (b == nb - 1) && !no_last;
                s_tuser = (b == user_beat);
                for (int i = 0; i < BY; i++) begin
                    q = b * BY + i;
                    if (q < len) begin
                        s_tdata[8*i +: 8] = frm[q];
                        s_tkeep[i] = 1'b1;
                    end else begin
                        s_tdata[8*i +: 8] = 8'($urandom);
                        s_tkeep[i] = 1'b0;
                    end
                end
                case (mode)
                    0: s_tready = 1'b1;
                    1: begin s_tready = ph; ph = ~ph; end
                    default: s_tready = 1'($urandom_range(0, 1));
                endcase
                @(posedge clk);
                done = s_tready;
            end
        end
    endtask

    // Counts negedges after the last transfer until csum_valid (bounded).
    task automatic wait_result(output int lat);
        lat = 0;
        while (lat < 30) begin
            @(negedge clk);
            if (lat == 0) begin s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; end
            lat++;
            if (csum_valid) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({csum_valid, csum, csum_ok, csum_err, csum_bytes, csum_overflow} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got v=%b csum=%h ok=%b err=%b bytes=%0d ovf=%b, need all zero",
                     csum_valid, csum, csum_ok, csum_err, csum_bytes, csum_overflow);
        end
    endtask

    task automatic test_ipv4();
        int lat;
        logic [15:0] c, nb;
        logic ok;
        build_ipv4();
        model(frm, seed, c, ok, nb);
        send_frame(0, -1, 1'b0);
        wait_result(lat);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL ipv4_latency: got %0d need 3", lat); end
        n_cmp++; if (csum !== 16'hB861) begin n_bad++; $display("FAIL ipv4_csum: got %h need b861", csum); end
        n_cmp++; if (csum !== c) begin n_bad++; $display("FAIL ipv4_csum_model: got %h need %h", csum, c); end
        n_cmp++; if (csum_ok !== 1'b1) begin n_bad++; $display("FAIL ipv4_ok: got %b need 1", csum_ok); end
        n_cmp++; if (csum_bytes !== 16'd20) begin n_bad++; $display("FAIL ipv4_bytes: got %0d need 20", csum_bytes); end
        n_cmp++; if (csum_err !== 1'b0) begin n_bad++; $display("FAIL ipv4_err: got %b need 0", csum_err); end
    endtask

    task automatic test_bad_ttl();
        int lat;
        build_ipv4();
        frm[22] = 8'h41;
        send_frame(0, -1, 1'b0);
        wait_result(lat);
        n_cmp++; if (csum !== 16'hB761) begin n_bad++; $display("FAIL badttl_csum: got %h need b761", csum); end
        n_cmp++; if (csum_ok !== 1'b0) begin n_bad++; $display("FAIL badttl_ok: got %b need 0", csum_ok); end
    endtask

    task automatic test_short();
        int lat;
        frm.delete();
        for (int i = 0; i < 14; i++) frm.push_back(8'(i));
        frm.push_back(8'hAB);
        send_frame(0, -1, 1'b0);
        wait_result(lat);
        n_cmp++; if (csum !== 16'h54FF) begin n_bad++; $display("FAIL short15_csum: got %h need 54ff", csum); end
        n_cmp++; if (csum_bytes !== 16'd1) begin n_bad++; $display("FAIL short15_bytes: got %0d need 1", csum_bytes); end
        n_cmp++; if (csum_ok !== 1'b0) begin n_bad++; $display("FAIL short15_ok: got %b need 0", csum_ok); end
        frm.delete();
        for (int i = 0; i < 10; i++) frm.push_back(8'($urandom));
        send_frame(0, -1, 1'b0);
        wait_result(lat);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL short10_latency: got %0d need 3", lat); end
        n_cmp++; if (csum !== 16'hFFFF) begin n_bad++; $display("FAIL short10_csum: got %h need ffff", csum); end
        n_cmp++; if (csum_bytes !== 16'd0) begin n_bad++; $display("FAIL short10_bytes: got %0d need 0", csum_bytes); end
    endtask

    task automatic test_tready_user();
        int lat;
        build_ipv4();
        send_frame(1, 2, 1'b0);
        wait_result(lat);
        n_cmp++; if (csum !== 16'hB861) begin n_bad++; $display("FAIL toggle_csum: got %h need b861", csum); end
        n_cmp++; if (csum_err !== 1'b1) begin n_bad++; $display("FAIL toggle_err: got %b need 1", csum_err); end
        n_cmp++; if (csum_ok !== 1'b1) begin n_bad++; $display("FAIL toggle_ok: got %b need 1", csum_ok); end
    endtask

    task automatic test_random();
        int lat, len, nbeats, ub;
        logic [15:0] c, nb, c0, nb0;
        logic ok, ok0;
        for (int k = 0; k < 40; k++) begin
            len = $urandom_range(1, 100);
            frm.delete();
            for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
`ifdef CSUM_STREAM_SEED_EN
            seed = 16'($urandom);
`endif
            if (len >= SKIP + 2 && $urandom_range(0, 1) == 1) begin
                frm[SKIP] = 8'h00;
                frm[SKIP+1] = 8'h00;
                model(frm, seed, c0, ok0, nb0);
                frm[SKIP] = c0[15:8];
                frm[SKIP+1] = c0[7:0];
            end
            model(frm, seed, c, ok, nb);
            nbeats = (len + BY - 1) / BY;
            ub = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nbeats - 1) : -1;
            send_frame(2, ub, 1'b0);
            wait_result(lat);
            n_cmp++;
            if (lat !== 3 || csum !== c || csum_ok !== ok || csum_bytes !== nb || csum_err !== (ub >= 0)) begin
                n_bad++;
                $display("FAIL random_%0d len=%0d: got lat=%0d csum=%h ok=%b bytes=%0d err=%b need lat=3 csum=%h ok=%b bytes=%0d err=%b",
                         k, len, lat, csum, csum_ok, csum_bytes, csum_err, c, ok, nb, ub >= 0);
            end
        end
        seed = '0;
    endtask

    task automatic test_back_to_back();
        int hs;
        csum_ready = 1'b0;
        build_ipv4();
        send_frame(0, -1, 1'b0);
        frm[22] = 8'h41;
        send_frame(0, -1, 1'b0);
        @(negedge clk);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++; if (csum_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid: got %b need 1", csum_valid); end
        n_cmp++; if (csum !== 16'hB761) begin n_bad++; $display("FAIL b2b_csum: got %h need b761", csum); end
        n_cmp++; if (csum_overflow !== 1'b1) begin n_bad++; $display("FAIL b2b_overflow: got %b need 1", csum_overflow); end
        csum_ready = 1'b1;
        hs = 0;
        for (int i = 0; i < 8; i++) begin
            if (csum_valid && csum_ready) hs++;
            @(negedge clk);
        end
        n_cmp++; if (hs !== 1) begin n_bad++; $display("FAIL b2b_handshakes: got %0d need 1", hs); end
    endtask

    task automatic test_reset_mid_frame();
        int lat, extra;
        build_ipv4();
        frm = frm[0:15];
        send_frame(0, -1, 1'b1);
        @(negedge clk);
        s_tvalid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (csum_overflow !== 1'b0 || csum_valid !== 1'b0) begin
            n_bad++; $display("FAIL midreset_clear: got ovf=%b v=%b need 0 0", csum_overflow, csum_valid);
        end
        build_ipv4();
        send_frame(0, -1, 1'b0);
        wait_result(lat);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL midreset_latency: got %0d need 3", lat); end
        n_cmp++; if (csum !== 16'hB861 || csum_ok !== 1'b1 || csum_bytes !== 16'd20) begin
            n_bad++; $display("FAIL midreset_result: got csum=%h ok=%b bytes=%0d need b861 1 20", csum, csum_ok, csum_bytes);
        end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (csum_valid) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL midreset_extra: got %0d more results need 0", extra); end
    endtask

    initial begin
        test_reset();
        test_ipv4();
        test_bad_ttl();
        test_short();
        test_tready_user();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
